// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: SRAM request payloads and destination-RAM id helper.
package vector_cache_pkg;

    localparam int unsigned INDEX_WIDTH   = 8;
    localparam int unsigned HASH_ID_W     = 2;
    localparam int unsigned TXN_ID_W      = 4;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned RAM_SEL_W     = 3;
    localparam int unsigned DEST_RAM_ID_W = HASH_ID_W + RAM_SEL_W;

    typedef struct packed {
        logic [HASH_ID_W-1:0]   hash_id;
        logic [INDEX_WIDTH-1:0] index;
        logic [TXN_ID_W-1:0]    txn_id;
    } arb_out_req_t;

    typedef struct packed {
        logic [HASH_ID_W-1:0]   hash_id;
        logic [INDEX_WIDTH-1:0] index;
        logic [DATA_W-1:0]      data;
    } write_ram_cmd_t;

    typedef logic [DEST_RAM_ID_W-1:0] dest_ram_id_t;

    // Physical SRAM instance addressed by a read: hash id plus top index bits.
    function automatic dest_ram_id_t get_dest_ram_id(input arb_out_req_t req);
        return {req.hash_id, req.index[INDEX_WIDTH-1 -: RAM_SEL_W]};
    endfunction

endpackage

// File: rtl/vc_sram_lane_arb.sv
// Per-lane read/write arbiter: eligibility, round-robin bit and write starvation counter.
module vc_sram_lane_arb #(
    parameter int unsigned WR_STARVE = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sched_en,
    input  logic rd_vld,
    input  logic wr_vld,
    input  logic wr_shadow,
    input  logic rd_gnt,
    input  logic wr_gnt,
    output logic rd_win_c,
    output logic wr_win_c
);

    logic             rr_q;
    logic [CNT_W-1:0] starve_q;
    logic             rd_elig;
    logic             wr_elig;
    logic             wr_forced;

    // rr_q = 1 means the last grant went to the read side, so the write is favoured next.
    always_comb begin
        rd_win_c  = 1'b0;
        wr_win_c  = 1'b0;
        rd_elig   = rd_vld && sched_en && !wr_shadow;
        wr_elig   = wr_vld && sched_en;
        wr_forced = (starve_q >= CNT_W'(WR_STARVE));
        if (rd_elig && wr_elig) begin
            if (wr_forced || rr_q) begin
                wr_win_c = 1'b1;
            end else begin
                rd_win_c = 1'b1;
            end
        end else begin
            rd_win_c = rd_elig;
            wr_win_c = wr_elig;
        end
    end

    // State updates follow the final grant, after pair resolution at the top level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= 1'b0;
            starve_q <= '0;
        end else if (sched_en) begin
            if (rd_gnt || wr_gnt) begin
                rr_q <= rd_gnt;
            end
            if (!wr_vld || wr_gnt) begin
                starve_q <= '0;
            end else if (starve_q != {CNT_W{1'b1}}) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vc_sram_lane_sched.sv
// Per-lane SRAM command scheduler with write-shadow and hash-pair read hazard avoidance.
// Optional checks compiled in with VC_SRAM_SCHED_ASSERT_EN.
module vc_sram_lane_sched
    import vector_cache_pkg::*;
#(
    parameter int unsigned LANES     = 8,
    parameter int unsigned WR_STARVE = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sched_en,
    input  logic [LANES-1:0]     rd_req_vld,
    input  arb_out_req_t         rd_req_pld [LANES],
    output logic [LANES-1:0]     rd_req_rdy,
    input  logic [LANES-1:0]     wr_req_vld,
    input  write_ram_cmd_t       wr_req_pld [LANES],
    output logic [LANES-1:0]     wr_req_rdy,
    output logic [LANES-1:0]     rd_cmd_vld,
    output arb_out_req_t         rd_cmd_pld [LANES],
    output logic [LANES-1:0]     wr_cmd_vld,
    output write_ram_cmd_t       wr_cmd_pld [LANES],
    output logic [15:0]          hazard_stall_cnt
);

    localparam int unsigned PAIRS = LANES / 2;
    localparam int unsigned HAZ_W = 16;

    logic [LANES-1:0] rd_win_c;
    logic [LANES-1:0] wr_win_c;
    logic [LANES-1:0] rd_drop_c;
    logic [LANES-1:0] rd_gnt_c;
    logic [LANES-1:0] wr_gnt_c;
    logic [PAIRS-1:0] pair_hit_c;
    logic [PAIRS-1:0] pair_tog_q;
    logic             stall_c;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vc_sram_lane_arb #(
            .WR_STARVE (WR_STARVE),
            .CNT_W     (CNT_W)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .sched_en  (sched_en),
            .rd_vld    (rd_req_vld[i]),
            .wr_vld    (wr_req_vld[i]),
            .wr_shadow (wr_cmd_vld[i]),
            .rd_gnt    (rd_gnt_c[i]),
            .wr_gnt    (wr_gnt_c[i]),
            .rd_win_c  (rd_win_c[i]),
            .wr_win_c  (wr_win_c[i])
        );
    end

    // Two reads to the same physical SRAM of a pair: pair_tog picks the survivor.
    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic hit;
        assign hit = rd_win_c[2*p] && rd_win_c[2*p+1] &&
                     (get_dest_ram_id(rd_req_pld[2*p]) == get_dest_ram_id(rd_req_pld[2*p+1]));
        assign pair_hit_c[p]  = hit;
        assign rd_drop_c[2*p]   = hit && pair_tog_q[p];
        assign rd_drop_c[2*p+1] = hit && !pair_tog_q[p];
    end

    assign rd_gnt_c   = rst_n ? (rd_win_c & ~rd_drop_c) : '0;
    assign wr_gnt_c   = rst_n ? wr_win_c : '0;
    assign rd_req_rdy = rd_gnt_c;
    assign wr_req_rdy = wr_gnt_c;
    assign stall_c    = |((rd_req_vld & wr_cmd_vld & {LANES{sched_en}}) | rd_drop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cmd_vld       <= '0;
            wr_cmd_vld       <= '0;
            pair_tog_q       <= '0;
            hazard_stall_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                rd_cmd_pld[i] <= '0;
                wr_cmd_pld[i] <= '0;
            end
        end else begin
            rd_cmd_vld <= rd_gnt_c;
            wr_cmd_vld <= wr_gnt_c;
            pair_tog_q <= pair_tog_q ^ pair_hit_c;
            if (stall_c && (hazard_stall_cnt != {HAZ_W{1'b1}})) begin
                hazard_stall_cnt <= hazard_stall_cnt + HAZ_W'(1);
            end
            for (int i = 0; i < LANES; i++) begin
                if (rd_gnt_c[i]) begin
                    rd_cmd_pld[i] <= rd_req_pld[i];
                end
                if (wr_gnt_c[i]) begin
                    wr_cmd_pld[i] <= wr_req_pld[i];
                end
            end
        end
    end

`ifdef VC_SRAM_SCHED_ASSERT_EN
    for (genvar a = 0; a < LANES; a++) begin : g_sva_lane
        a_wr_then_rd: assert property (@(posedge clk) disable iff (!rst_n)
            wr_cmd_vld[a] |=> !rd_cmd_vld[a])
            else $error("read issued right after write on lane %0d", a);
        a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
            !(rd_gnt_c[a] && wr_gnt_c[a]))
            else $error("two grants on lane %0d", a);
        a_rd_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (rd_req_vld[a] && !rd_req_rdy[a]) |=> (rd_req_vld[a] && $stable(rd_req_pld[a])))
            else $error("read request dropped or changed on lane %0d", a);
        a_wr_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (wr_req_vld[a] && !wr_req_rdy[a]) |=> (wr_req_vld[a] && $stable(wr_req_pld[a])))
            else $error("write request dropped or changed on lane %0d", a);
    end
    for (genvar q = 0; q < PAIRS; q++) begin : g_sva_pair
        a_pair_rd: assert property (@(posedge clk) disable iff (!rst_n)
            !(rd_cmd_vld[2*q] && rd_cmd_vld[2*q+1] &&
              (get_dest_ram_id(rd_cmd_pld[2*q]) == get_dest_ram_id(rd_cmd_pld[2*q+1]))))
            else $error("same-SRAM reads in pair %0d", q);
    end
`endif

endmodule
